// File: rtl/ctrl_pkg.sv
// Shared encodings for the control unit: FSM state codes, opcodes, ALU and PC-source selects.
package ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;
  localparam state_t S_TRAP   = 3'd6;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

endpackage

// File: rtl/control_unit_if.sv
// Instruction/data memory request-acknowledge signals between the control unit and memory.
// A request is held high until its ack arrives; an ack seen while the request is low is ignored.
interface control_unit_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, output dmem_req, output dmem_we,
                    input  imem_ack, input  dmem_ack);
    modport slave  (input  imem_req, input  dmem_req, input  dmem_we,
                    output imem_ack, output dmem_ack);
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], plus HALT and TRAP.
// Define ILLEGAL_OP_TRAP_EN to trap undefined opcodes; otherwise they execute as NOP.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic                  zero,
    control_unit_if.master        mem,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [1:0]            pc_src,
    output logic [1:0]            alu_op,
    output logic                  alu_src_imm,
    output logic                  reg_we,
    output logic                  wb_sel,
    output logic                  halted,
    output logic                  illegal,
    output logic [2:0]            state
);

    if (PC_W < 3) begin : g_pc_w_check
        $error("control_unit: PC_W must be at least 3");
    end

    state_t     state_q, state_d;
    logic [5:0] op_q;
    // run_q keeps imem_req low until the first clock edge after reset release.
    logic       run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= OP_NOP;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (run_q && mem.imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_ADDI:             state_d = S_WB;
                    OP_LW, OP_SW:        state_d = S_MEM;
                    OP_HALT:             state_d = S_HALT;
                    OP_NOP, OP_J, OP_BEQ: state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:             state_d = S_TRAP;
`else
                    default:             state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM:    if (mem.dmem_ack) state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        pc_src       = PC_SEQ;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem.imem_req = run_q;
                ir_load      = run_q & mem.imem_ack;
                pc_inc       = run_q & mem.imem_ack;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_op      = ALU_ADD;
                        alu_src_imm = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        if (zero) begin
                            pc_load = 1'b1;
                            pc_src  = PC_BRANCH;
                        end
                    end
                    OP_J: begin
                        pc_load = 1'b1;
                        pc_src  = PC_JUMP;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (op_q == OP_SW);
                alu_op       = ALU_ADD;
                alu_src_imm  = 1'b1;
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign halted = (state_q == S_HALT) || (state_q == S_TRAP);
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal = (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif
    assign state = state_q;

endmodule
